// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one sequential radix-2 Booth multiplier
// between two requesters and returns each product over a valid/ready channel.

module booth #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           start,
    input  logic [W-1:0]   mc,
    input  logic [W-1:0]   mp,
    output logic [2*W-1:0] prod
);
    // One guard bit on the accumulator so that subtracting mc=-128 cannot overflow.
    logic [W:0]   acc;
    logic [W:0]   m_ext;
    logic [W:0]   sum;
    logic [W-1:0] mq;
    logic [W-1:0] m;
    logic         q_1;

    assign m_ext = {m[W-1], m};

    always_comb begin
        sum = acc;
        case ({mq[0], q_1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
    end

    // Free-runs after load; the owner decides which cycle's product is valid.
    always_ff @(posedge clk) begin
        if (start) begin
            acc <= '0;
            mq  <= mp;
            m   <= mc;
            q_1 <= 1'b0;
        end else begin
            {acc, mq, q_1} <= {sum[W], sum, mq};
        end
    end

    assign prod = {acc[W-1:0], mq};
endmodule

module booth_mul_arbiter #(
    parameter int STEPS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_mc,
    input  logic [7:0]  req0_mp,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_mc,
    input  logic [7:0]  req1_mp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_prod,
    output logic        rsp_id,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam int CW = $clog2(STEPS + 1);

    logic [1:0]    state;
    logic          rr_ptr;
    logic [CW-1:0] cnt;
    logic [7:0]    op_mc;
    logic [7:0]    op_mp;
    logic          id_q;
    logic          grant_any;
    logic          grant_id;
    logic          core_start;
    logic [15:0]   core_prod;

    // rr_ptr names the favoured requester when both are asking.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    end

    assign req0_ready = !reset && (state == IDLE) && grant_any && !grant_id;
    assign req1_ready = !reset && (state == IDLE) && grant_any &&  grant_id;
    assign rsp_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign core_start = !reset && (state == LOAD);

    booth #(.W(8)) u_core (
        .clk   (clk),
        .start (core_start),
        .mc    (op_mc),
        .mp    (op_mp),
        .prod  (core_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            cnt      <= '0;
            op_mc    <= '0;
            op_mp    <= '0;
            id_q     <= 1'b0;
            rsp_prod <= '0;
            rsp_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_mc  <= grant_id ? req1_mc : req0_mc;
                        op_mp  <= grant_id ? req1_mp : req0_mp;
                        id_q   <= grant_id;
                        rr_ptr <= ~grant_id;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // cnt==STEPS means the core has finished exactly STEPS steps.
                    if (cnt == CW'(STEPS)) begin
                        rsp_prod <= core_prod;
                        rsp_id   <= id_q;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench: accepts push hand-computed products, a monitor pops on each response.

module tb_booth_mul_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_mc, req0_mp, req1_mc, req1_mp;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_prod;

    typedef struct packed {
        logic        id;
        logic [15:0] prod;
    } exp_t;

    exp_t        sb[$];
    logic        grants[$];
    logic [15:0] exp_prod0, exp_prod1;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        popped;

    booth_mul_arbiter #(.STEPS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_mc    (req0_mc),
        .req0_mp    (req0_mp),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_mc    (req1_mc),
        .req1_mp    (req1_mp),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_prod   (rsp_prod),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, exp_prod0});
                grants.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, exp_prod1});
                grants.push_back(1'b1);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                popped = sb.pop_front();
                check("rsp_prod", {16'd0, rsp_prod}, {16'd0, popped.prod});
                check("rsp_id", {31'd0, rsp_id}, {31'd0, popped.id});
            end
        end
    end

    task automatic drive(input logic id, input logic v, input logic [7:0] mc, input logic [7:0] mp,
                         input logic [15:0] e);
        if (id) begin
            req1_mc = mc; req1_mp = mp; exp_prod1 = e; req1_valid = v;
        end else begin
            req0_mc = mc; req0_mp = mp; exp_prod0 = e; req0_valid = v;
        end
    endtask

    task automatic wait_ready(input logic id, output int acc_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 100);
        check("accept_timeout", {31'd0, n < 100}, 32'd1);
        acc_cyc = cyc + 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 300);
        check("idle_timeout", {31'd0, n < 300}, 32'd1);
    endtask

    // Single request with latency and post-handshake checks; rsp_ready must be high.
    task automatic run_one(input logic id, input logic [7:0] mc, input logic [7:0] mp,
                           input logic [15:0] e);
        int acc_cyc;
        int n = 0;
        @(posedge clk); #1;
        drive(id, 1'b1, mc, mp, e);
        wait_ready(id, acc_cyc);
        @(negedge clk);
        check("ready_one_cycle", {31'd0, id ? req1_ready : req0_ready}, 32'd0);
        check("busy_in_load", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        drive(id, 1'b0, mc, mp, e);
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        check("latency", cyc - acc_cyc, 32'd10);
        @(negedge clk);
        check("busy_after_rsp", {31'd0, busy}, 32'd0);
        check("valid_after_rsp", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc_cyc, bad, n;
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_mc = '0; req0_mp = '0; req1_mc = '0; req1_mp = '0;
        exp_prod0 = '0; exp_prod1 = '0;
        repeat (3) @(posedge clk);
        #1 req0_valid = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_prod", {16'd0, rsp_prod}, 32'd0);
        check("rst_id", {31'd0, rsp_id}, 32'd0);
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; reset = 1'b0;

        run_one(1'b0, 8'd3, 8'd5, 16'h000F);

        run_one(1'b1, 8'hFD, 8'h05, 16'hFFF1);
        run_one(1'b1, 8'h80, 8'h80, 16'h4000);
        run_one(1'b1, 8'h7F, 8'h80, 16'hC080);
        run_one(1'b1, 8'h00, 8'hFF, 16'h0000);

        // Both requesters held valid: grants must alternate starting with 0.
        grants.delete();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'd2, 8'd2, 16'h0004);
        drive(1'b1, 1'b1, 8'd3, 8'd3, 16'h0009);
        n = 0;
        while (grants.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        check("rr_grant_count", grants.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check("rr_grant_order", {31'd0, (i < grants.size()) ? grants[i] : 1'bx}, i % 2);

        // Consumer stall: result held, no accepts, resume right after handshake.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 8'd5, 8'd6, 16'h001E);
        wait_ready(1'b0, acc_cyc);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        check("stall_latency", cyc - acc_cyc, 32'd10);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'd2, 8'd3, 16'h0006);
        drive(1'b1, 1'b1, 8'd1, 8'd1, 16'h0001);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_prod !== 16'h001E || rsp_id !== 1'b0 || req0_ready || req1_ready)
                bad++;
        end
        check("stall_bad_cycles", bad, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_no_accept_on_hs", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        check("resume_req1_ready", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_ready(1'b0, acc_cyc);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_idle();

        // Reset while RUN holds counter=4.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'd9, 8'd9, 16'h0051);
        wait_ready(1'b0, acc_cyc);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        run_one(1'b0, 8'd7, 8'hF9, 16'hFFCF);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
